// File: rtl/mac_engine_multilane_pkg.sv
// Shared constants and control/flag bundles for the multi-lane MAC engine.
package mac_engine_multilane_pkg;

  localparam int MAC_NB_LANES   = 4;
  localparam int MAC_DATA_WIDTH = 16;
  localparam int MAC_ACC_WIDTH  = 48;
  localparam int MAC_OUT_WIDTH  = 32;
  localparam int MAC_CNT_LEN    = 1024;
  localparam int MAC_SHIFT_W    = $clog2(MAC_ACC_WIDTH);
  localparam int MAC_LEN_W      = $clog2(MAC_CNT_LEN) + 1;

  typedef struct packed {
    logic                   clear;
    logic                   enable;
    logic                   simple_mul;
    logic                   start;
    logic [MAC_SHIFT_W-1:0] shift;
    logic [MAC_LEN_W-1:0]   len;
  } ctrl_engine_ml_t;

  typedef struct packed {
    logic [MAC_LEN_W-1:0]    cnt;
    logic                    busy;
    logic [MAC_NB_LANES-1:0] ovf;
  } flags_engine_ml_t;

endpackage

// File: rtl/mac_engine_multilane_lane.sv
// One MAC lane: S1 product/bias register, accumulator, shift+saturate into d.
// Latency 2 from fire to d; all state freezes while the shared pipeline is stalled.
module mac_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_WIDTH  = 32,
  parameter int SHIFT_W    = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic                        fire_i,
  input  logic                        s2_en_i,
  input  logic                        last_i,
  input  logic                        simple_i,
  input  logic [SHIFT_W-1:0]          shift_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [OUT_WIDTH-1:0]  c_i,
  output logic [OUT_WIDTH-1:0]        d_o,
  output logic                        ovf_o
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = ACC_WIDTH + 1;

  logic signed [PROD_W-1:0]    prod_q, prod_d;
  logic signed [OUT_WIDTH-1:0] c_q, c_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0]        d_q, d_d;
  logic                        ovf_q, ovf_d;

  logic signed [SUM_W-1:0] acc_ext, prod_ext, c_ext, total, shifted, result;
  logic [OUT_WIDTH-1:0]    sat_val;
  logic                    clamp;

  // Final value is formed one bit wider than the accumulator so c can be added without wrap.
  always_comb begin
    acc_ext  = simple_i ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
    prod_ext = {{(SUM_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    c_ext    = simple_i ? '0 : {{(SUM_W-OUT_WIDTH){c_q[OUT_WIDTH-1]}}, c_q};
    total    = acc_ext + prod_ext;
    shifted  = total >>> shift_i;
    result   = shifted + c_ext;
    clamp    = (result[SUM_W-1:OUT_WIDTH-1] != {(SUM_W-OUT_WIDTH+1){result[SUM_W-1]}});
    if (!clamp) begin
      sat_val = result[OUT_WIDTH-1:0];
    end else if (result[SUM_W-1]) begin
      sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    prod_d = prod_q;
    c_d    = c_q;
    acc_d  = acc_q;
    d_d    = d_q;
    ovf_d  = ovf_q;
    if (clear_i) begin
      prod_d = '0;
      c_d    = '0;
      acc_d  = '0;
      d_d    = '0;
      ovf_d  = 1'b0;
    end else begin
      if (fire_i) begin
        prod_d = a_i * b_i;
        c_d    = c_i;
      end
      if (s2_en_i) begin
        if (last_i) begin
          d_d   = sat_val;
          acc_d = '0;
          ovf_d = ovf_q | clamp;
        end else begin
          acc_d = acc_q + {{(ACC_WIDTH-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        end
      end
      if (start_i) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      c_q    <= '0;
      acc_q  <= '0;
      d_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      c_q    <= c_d;
      acc_q  <= acc_d;
      d_q    <= d_d;
      ovf_q  <= ovf_d;
    end
  end

  assign d_o   = d_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_engine_multilane.sv
// NB_LANES signed MAC lanes sharing one joint a/b/c handshake, beat counter and config.
// Latency 2 from fire to d_valid_o; a held d (valid & ~ready) or enable_i low stops new beats.
module mac_engine_multilane
  import mac_engine_multilane_pkg::*;
#(
  parameter int NB_LANES   = MAC_NB_LANES,
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int ACC_WIDTH  = MAC_ACC_WIDTH,
  parameter int OUT_WIDTH  = MAC_OUT_WIDTH,
  parameter int CNT_LEN    = MAC_CNT_LEN
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  logic                           start_i,
  input  logic                           simple_mul_i,
  input  logic [$clog2(ACC_WIDTH)-1:0]   shift_i,
  input  logic [$clog2(CNT_LEN):0]       len_i,
  input  logic [NB_LANES*DATA_WIDTH-1:0] a_data_i,
  input  logic [NB_LANES*DATA_WIDTH-1:0] b_data_i,
  input  logic                           a_valid_i,
  input  logic                           b_valid_i,
  output logic                           a_ready_o,
  output logic                           b_ready_o,
  input  logic [NB_LANES*OUT_WIDTH-1:0]  c_data_i,
  input  logic                           c_valid_i,
  output logic                           c_ready_o,
  output logic [NB_LANES*OUT_WIDTH-1:0]  d_data_o,
  output logic                           d_valid_o,
  input  logic                           d_ready_i,
  output logic [$clog2(CNT_LEN):0]       cnt_o,
  output logic                           busy_o,
  output logic [NB_LANES-1:0]            ovf_o
);

  localparam int SHIFT_W = $clog2(ACC_WIDTH);
  localparam int LEN_W   = $clog2(CNT_LEN) + 1;

  ctrl_engine_ml_t  ctrl;
  flags_engine_ml_t flags;

  logic               simple_q, simple_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s1_last_q, s1_last_d;
  logic               d_vld_q, d_vld_d;

  logic                stall, adv, end_beat, c_need, fire;
  logic [NB_LANES-1:0] lane_ovf;

  assign ctrl = '{clear: clear_i, enable: enable_i, simple_mul: simple_mul_i,
                  start: start_i, shift: shift_i, len: len_i};

  always_comb begin
    stall    = d_vld_q & ~d_ready_i;
    adv      = ctrl.enable & ~stall;
    end_beat = (cnt_q == len_q - LEN_W'(1));
    c_need   = ~simple_q & end_beat;
    // Beats coinciding with start/clear are refused so they never mix with the new config.
    fire     = active_q & adv & a_valid_i & b_valid_i & (c_valid_i | ~c_need)
               & ~ctrl.start & ~ctrl.clear;
  end

  always_comb begin
    simple_d  = simple_q;
    shift_d   = shift_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    s1_vld_d  = s1_vld_q;
    s1_last_d = s1_last_q;
    d_vld_d   = d_vld_q;
    if (ctrl.clear) begin
      simple_d  = 1'b0;
      shift_d   = '0;
      len_d     = '0;
      cnt_d     = '0;
      active_d  = 1'b0;
      s1_vld_d  = 1'b0;
      s1_last_d = 1'b0;
      d_vld_d   = 1'b0;
    end else begin
      if (ctrl.start) begin
        simple_d = ctrl.simple_mul;
        shift_d  = ctrl.shift;
        len_d    = ctrl.len;
        cnt_d    = '0;
        active_d = (ctrl.len != '0);
      end else if (fire) begin
        cnt_d    = end_beat ? '0 : cnt_q + LEN_W'(1);
        active_d = ~end_beat;
      end
      if (adv) begin
        s1_vld_d  = fire;
        s1_last_d = fire & (simple_q | end_beat);
        d_vld_d   = s1_vld_q & s1_last_q;
      end else if (d_vld_q & d_ready_i) begin
        // Sink took d while enable_i is low: drop valid so it is not delivered twice.
        d_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      simple_q  <= 1'b0;
      shift_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      d_vld_q   <= 1'b0;
    end else begin
      simple_q  <= simple_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      d_vld_q   <= d_vld_d;
    end
  end

  for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_W    (SHIFT_W)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (ctrl.clear),
      .start_i  (ctrl.start),
      .fire_i   (fire),
      .s2_en_i  (adv & s1_vld_q),
      .last_i   (s1_last_q),
      .simple_i (simple_q),
      .shift_i  (shift_q),
      .a_i      (a_data_i[l*DATA_WIDTH +: DATA_WIDTH]),
      .b_i      (b_data_i[l*DATA_WIDTH +: DATA_WIDTH]),
      .c_i      (c_data_i[l*OUT_WIDTH +: OUT_WIDTH]),
      .d_o      (d_data_o[l*OUT_WIDTH +: OUT_WIDTH]),
      .ovf_o    (lane_ovf[l])
    );
  end

  assign flags = '{cnt: cnt_q, busy: active_q | s1_vld_q | d_vld_q, ovf: lane_ovf};

  assign a_ready_o = fire;
  assign b_ready_o = fire;
  assign c_ready_o = fire & c_need;
  assign d_valid_o = d_vld_q;
  assign cnt_o     = flags.cnt;
  assign busy_o    = flags.busy;
  assign ovf_o     = flags.ovf;

endmodule

// File: doc/mac_engine_multilane.md
Name: mac_engine_multilane

Overview:
- Parametrised successor of the single-lane MAC engine: NB_LANES independent signed MAC lanes sharing one control, handshake and counter.
- Modes: element-wise multiply (simple_mul) or length-len scalar product plus bias c; arithmetic right shift and saturation to OUT_WIDTH.
- Sits between the streamer sources (a, b, c) / sink (d) and the control FSM, driven by ctrl_engine_t and reporting flags_engine_t.

Parameters:
- NB_LANES, 4, number of parallel lanes
- DATA_WIDTH, 16, signed width of each a/b element
- ACC_WIDTH, 48, signed accumulator width per lane
- OUT_WIDTH, 32, signed width of each c/d element
- CNT_LEN, 1024, maximum vector length

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of all state
- enable_i  in  1  global enable; low freezes the pipeline
- start_i  in  1  pulse: latch config, zero counter and accumulators
- simple_mul_i  in  1  mode select, sampled on start_i
- shift_i  in  $clog2(ACC_WIDTH)  right shift amount, sampled on start_i
- len_i  in  $clog2(CNT_LEN)+1  vector length, sampled on start_i
- a_data_i / b_data_i  in  NB_LANES*DATA_WIDTH  operand lanes (lane 0 at LSBs)
- a_valid_i / b_valid_i  in  1  operand valid
- a_ready_o / b_ready_o  out  1  operand ready
- c_data_i  in  NB_LANES*OUT_WIDTH  bias lanes
- c_valid_i  in  1  bias valid
- c_ready_o  out  1  bias ready
- d_data_o  out  NB_LANES*OUT_WIDTH  result lanes
- d_valid_o  out  1  result valid
- d_ready_i  in  1  result ready
- cnt_o  out  $clog2(CNT_LEN)+1  beats accepted in current vector
- busy_o  out  1  job active or pipeline non-empty
- ovf_o  out  NB_LANES  sticky per-lane saturation flag

Behaviour:
- Reset and clear_i: all outputs 0; cnt 0, accumulators 0, pipe valids 0, ovf 0, config regs 0 (simple_mul=0, len=0). clear_i has priority over start_i and all handshakes.
- start_i (no clear): latch mode/shift/len; cnt, acc and ovf to 0; job active iff len!=0; beats presented in the same cycle are not accepted.
- len==0: start_i leaves the engine idle. No beats are accepted and no d is emitted.
- stall = d_valid_o & ~d_ready_i. adv = enable_i & ~stall.
- Beat fire requires: job active, adv, a_valid_i, b_valid_i, and c_valid_i when c is needed.
  - c is needed only on the last beat (cnt==len-1) in scalar mode.
  - In simple_mul, c_ready_o stays 0.
  - a_ready_o/b_ready_o/c_ready_o are asserted only when the beat fires (joint handshake).
- Pipeline: S1 registers the full 2*DATA_WIDTH signed product per lane, plus valid/last/c. S2 registers into d.
- simple_mul: every fired beat is last. d = sat((a*b)>>>shift). Latency 2 cycles from fire to d_valid_o.
- Scalar product:
  - Non-last S1 beats: acc += sext(product).
  - Last beat: d = sat(c + ((acc+product)>>>shift)), computed in ACC_WIDTH+1 bits; acc cleared in the same cycle.
  - Latency 2 cycles from last-beat fire to d_valid_o.
- cnt_o increments on each fire. At the last fire it returns to 0 and the job ends (in simple_mul, after len beats).
- sat: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Any clamp sets ovf_o[lane] until the next start/clear. Accumulator wrap is not detected (caller bounds len).
- enable_i low or stall freezes S1, S2 and the accumulators. d_data_o/d_valid_o hold stable while stalled.
- busy_o = job active | S1 valid | d_valid_o.
- rst_ni mid-job: immediate return to reset values. No partial d is emitted afterwards.

Decomposition:
- Shared package additions: MAC_NB_LANES and MAC_ACC_WIDTH constants; ctrl_engine_ml_t (clear, enable, simple_mul, start, shift, len) and flags_engine_ml_t (cnt, busy, ovf[NB_LANES]).
- Natural sub-module: mac_lane (per-lane S1 product, accumulator, shift/saturate, ovf), instantiated in a generate loop. The top holds the handshake, counter and config registers.

Test Plan:
- Scalar mode, len=4, shift=0, all lanes a=3, b=5, c=7 on the last beat → single d per lane = 67, d_valid 2 cycles after the 4th fire; cnt_o goes 1,2,3,0.
- simple_mul, shift=2, a=-8, b=3 → d=-6 each beat; c_ready_o stays 0; 3 back-to-back beats give 3 consecutive d.
- Saturation: OUT_WIDTH=32, len=1, a=b=32767, shift=0, c=2^31-1 → d=2147483647 and ovf_o=all ones; next start clears ovf_o.
- Backpressure: d_ready_i low for 5 cycles in simple_mul → at most 2 beats accepted beyond the held d; d stable; no beat lost or duplicated after release.
- start_i with len=0 → no readies, busy_o=0, no d. Then clear_i mid-vector (cnt=2 of 4) → cnt=0, busy_o=0, no d emitted.
- Async rst_ni low mid-pipeline with d_valid_o=1 → d_valid_o=0 immediately; all readies 0 until the next start_i.
